systolic_feeder: RTL and testbench

- Upstream operand-staging stage for the output-stationary FP8 E4M3 PE array.
- Accepts matrices A and B (N x N, FP8) over a byte-wide valid/ready load port into internal buffers.
- On start, pulses the array clear, then streams A rows into the left edge and B columns into the top edge with the diagonal skew the systolic array requires.
- Drives zeros outside the active window and flags completion once every PE holds its final dot product.

---
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: operand-staging stage for an output-stationary FP8 PE array.
// Buffers A and B from a byte-wide load port, then streams skewed rows/columns
// into the array edges after a one-cycle accumulator clear.
module systolic_feeder #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                start,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic                clear_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned NN     = N * N;
    localparam int unsigned CNT_W  = $clog2(2 * NN + 1);
    localparam int unsigned T_W    = $clog2(3 * N - 2);
    localparam int unsigned IDX_W  = $clog2(NN);
    localparam int unsigned T_LAST = 3 * N - 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FULL   = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [T_W-1:0]      t;
    logic [T_W-1:0]      t_n;
    logic                accept;
    logic [N*DATA_W-1:0] a_edge_n;
    logic [N*DATA_W-1:0] b_edge_n;

    logic [DATA_W-1:0]   a_buf [NN];
    logic [DATA_W-1:0]   b_buf [NN];

    // Next-state, load counter and stream counter decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        t_n     = t;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(2 * NN - 1)) begin
                        state_n = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (start) begin
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_n = S_STREAM;
                t_n     = '0;
            end
            S_STREAM: begin
                if (t == T_W'(T_LAST)) begin
                    state_n = S_DONE;
                end else begin
                    t_n = t + T_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Skewed edge operands for the upcoming cycle; zero outside the active diagonal window
    always_comb begin
        a_edge_n = '0;
        b_edge_n = '0;
        if (state_n == S_STREAM) begin
            for (int i = 0; i < int'(N); i++) begin
                if (int'(t_n) >= i && int'(t_n) < i + int'(N)) begin
                    a_edge_n[DATA_W*i +: DATA_W] = a_buf[IDX_W'(i * int'(N) + (int'(t_n) - i))];
                    b_edge_n[DATA_W*i +: DATA_W] = b_buf[IDX_W'((int'(t_n) - i) * int'(N) + i)];
                end
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            t     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            t     <= t_n;
        end
    end

    // Operand buffers: A fills first, then B, both row-major
    always_ff @(posedge clk) begin
        if (accept) begin
            if (cnt < CNT_W'(NN)) begin
                a_buf[IDX_W'(cnt)] <= in_data;
            end else begin
                b_buf[IDX_W'(cnt - CNT_W'(NN))] <= in_data;
            end
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            a_edge    <= '0;
            b_edge    <= '0;
            clear_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_ready  <= (state_n == S_IDLE);
            a_edge    <= a_edge_n;
            b_edge    <= b_edge_n;
            clear_out <= (state_n == S_CLEAR);
            busy      <= (state_n == S_CLEAR) || (state_n == S_STREAM);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (N=2): expected edge/flag records are
// queued per job and a negedge monitor pops them whenever the DUT shows activity.
module tb_systolic_feeder;

    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int W      = N * DATA_W;

    localparam int K_IDLE = 0;
    localparam int K_CLR  = 1;
    localparam int K_STR  = 2;
    localparam int K_DONE = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              start;
    logic [W-1:0]      a_edge;
    logic [W-1:0]      b_edge;
    logic              clear_out;
    logic              busy;
    logic              done;

    typedef struct {
        int           kind;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    systolic_feeder #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .clear_out (clear_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: pop an expected record for every cycle the DUT shows clear/stream/done
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (!rst) begin
            k = clear_out ? K_CLR : (done ? K_DONE : (busy ? K_STR : K_IDLE));
            if (k == K_IDLE) begin
                if (a_edge != '0 || b_edge != '0) chk("idle_edges", {a_edge, b_edge}, 32'h0);
            end else if (q.size() == 0) begin
                chk("unexpected_activity", 32'(k), 32'(K_IDLE));
            end else begin
                e = q.pop_front();
                chk("kind",      32'(k),         32'(e.kind));
                chk("a_edge",    32'(a_edge),    32'(e.a));
                chk("b_edge",    32'(b_edge),    32'(e.b));
                chk("busy",      32'(busy),      32'(e.kind != K_DONE));
                chk("clear_out", 32'(clear_out), 32'(e.kind == K_CLR));
                chk("done",      32'(done),      32'(e.kind == K_DONE));
            end
        end
    end

    task automatic push(input int kind, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        q.push_back(e);
    endtask

    // A = [1,2;3,4], B = identity; edges packed {row1,row0} / {col1,col0}
    task automatic push_job_ident();
        push(K_CLR,  16'h0000, 16'h0000);
        push(K_STR,  16'h0038, 16'h0038);
        push(K_STR,  16'h4440, 16'h0000);
        push(K_STR,  16'h4800, 16'h3800);
        push(K_STR,  16'h0000, 16'h0000);
        push(K_DONE, 16'h0000, 16'h0000);
    endtask

    // A = B = all 2.0
    task automatic push_job_twos();
        push(K_CLR,  16'h0000, 16'h0000);
        push(K_STR,  16'h0040, 16'h0040);
        push(K_STR,  16'h4040, 16'h4040);
        push(K_STR,  16'h4000, 16'h4000);
        push(K_STR,  16'h0000, 16'h0000);
        push(K_DONE, 16'h0000, 16'h0000);
    endtask

    task automatic load_byte(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_range(input logic [63:0] v, input int first, input int last);
        for (int k = first; k <= last; k++) load_byte(v[63-8*k -: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'h0);
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'h1);
        chk({name, "_busy"},     32'(busy),     32'h0);
    endtask

    localparam logic [63:0] JOB_IDENT = 64'h38404448_38000038;
    localparam logic [63:0] JOB_TWOS  = 64'h40404040_40404040;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        #12;
        chk("rst_a_edge",   32'(a_edge),    32'h0);
        chk("rst_b_edge",   32'(b_edge),    32'h0);
        chk("rst_clear",    32'(clear_out), 32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_done",     32'(done),      32'h0);
        chk("rst_in_ready", 32'(in_ready),  32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Partial load then start: must be ignored
        load_range(JOB_IDENT, 0, 4);
        pulse_start();
        @(posedge clk);
        #1;
        chk("partial_start_busy",     32'(busy),     32'h0);
        chk("partial_start_in_ready", 32'(in_ready), 32'h1);
        chk("partial_start_clear",    32'(clear_out), 32'h0);
        load_range(JOB_IDENT, 5, 6);
        chk("seven_bytes_in_ready", 32'(in_ready), 32'h1);
        load_range(JOB_IDENT, 7, 7);
        chk("full_in_ready", 32'(in_ready), 32'h0);

        // Job 1 with in_valid held high through FULL/CLEAR/STREAM
        in_valid = 1'b1;
        in_data  = 8'hAA;
        push_job_ident();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("job_ident");

        // Back-to-back job 2; last byte coincides with start
        load_range(JOB_TWOS, 0, 6);
        chk("job2_seven_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_data  = 8'h40;
        start    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        chk("same_edge_in_ready", 32'(in_ready),  32'h0);
        chk("same_edge_clear",    32'(clear_out), 32'h0);
        chk("same_edge_busy",     32'(busy),      32'h0);
        @(posedge clk);
        #1;
        chk("full_hold_clear", 32'(clear_out), 32'h0);
        chk("full_hold_busy",  32'(busy),      32'h0);
        push_job_twos();
        pulse_start();
        wait_drain("job_twos");

        // Async reset during STREAM t=1
        load_range(JOB_IDENT, 0, 7);
        push_job_ident();
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #6;
        rst = 1'b1;
        #1;
        chk("async_a_edge", 32'(a_edge),    32'h0);
        chk("async_b_edge", 32'(b_edge),    32'h0);
        chk("async_clear",  32'(clear_out), 32'h0);
        chk("async_busy",   32'(busy),      32'h0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Recovery job after reset
        load_range(JOB_TWOS, 0, 7);
        chk("recover_full_in_ready", 32'(in_ready), 32'h0);
        push_job_twos();
        pulse_start();
        wait_drain("job_recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
